// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage register slice.
//   stage_state_e : occupancy state of the elastic stage (EMPTY=0, ONE=1, FULL=2)
//   BUBBLE_FILL   : fill bit used to build the default bubble payload
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // Default bubble payload is all-zeros; replicated to the payload width.
    localparam logic BUBBLE_FILL = 1'b0;

endpackage

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
// Enabled up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears the count
//   en    : count this cycle
//   count : current count value (WIDTH bits)
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Two-entry elastic pipeline register (main + skid) carrying a PC and a
// payload. in_ready depends only on registered state, so there is no
// combinational path from out_ready back to in_ready.
// Optional statistics: define PIPE_STAGE_STATS_EN to add stall_cnt/flush_cnt.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   in_valid/in_ready       : upstream handshake
//   in_pc/in_data           : upstream entry
//   flush                   : synchronous squash of all held entries
//   out_valid/out_ready     : downstream handshake
//   out_pc/out_data         : presented entry (0 / BUBBLE when empty)
//   stall_cnt, flush_cnt    : saturating statistics (PIPE_STAGE_STATS_EN only)
//   occupancy               : entries held, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          WIDTH     = 32,
    parameter int unsigned          PC_WIDTH  = 32,
    parameter logic [WIDTH-1:0]     BUBBLE    = {WIDTH{BUBBLE_FILL}},
    parameter int unsigned          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [WIDTH-1:0]     out_data,
`ifdef PIPE_STAGE_STATS_EN
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
`endif
    output logic [1:0]           occupancy
);

    stage_state_e        state;
    stage_state_e        state_nx;

    logic [PC_WIDTH-1:0] main_pc;
    logic [WIDTH-1:0]    main_data;
    logic [PC_WIDTH-1:0] skid_pc;
    logic [WIDTH-1:0]    skid_data;

    logic                in_fire;
    logic                out_fire;
    logic                load_main_in;
    logic                load_main_skid;
    logic                load_skid;

    // reset gates in_ready directly so it drops the moment reset asserts.
    assign in_ready  = !reset && (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_pc    = out_valid ? main_pc   : '0;
    assign out_data  = out_valid ? main_data : BUBBLE;
    assign occupancy = 2'(state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nx     = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_nx  = ST_FULL;
                    load_skid = 1'b1;
                end else if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (out_fire) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_nx       = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
        // Flush overrides everything; a same-cycle out_fire has already been
        // taken downstream, a same-cycle in_fire is simply never stored.
        if (flush) begin
            state_nx       = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_pc   <= '0;
            main_data <= '0;
            skid_pc   <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_in) begin
                main_pc   <= in_pc;
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_pc   <= skid_pc;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_pc   <= in_pc;
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic stall_en;
    logic flush_en;

    assign stall_en = out_valid && !out_ready;
    assign flush_en = flush && (state != ST_EMPTY);

    pipe_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en),
        .count (stall_cnt)
    );

    pipe_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_en),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Scoreboard bench for pipe_stage_reg. Accepted entries are queued as they
// are issued; a negedge monitor pops and compares on every out_fire, checks
// that stalled outputs hold the head entry, and checks bubble output when
// empty. Directed checks cover occupancy, in_ready, flush and reset.
// Statistics checks are built when PIPE_STAGE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB = 32'hBAD0_B0B0;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [1:0]  stall_cnt;
    logic [1:0]  flush_cnt;
`endif

    int n_cmp;
    int n_bad;
    logic [63:0] exp_q[$];

    pipe_stage_reg #(
        .WIDTH     (32),
        .PC_WIDTH  (32),
        .BUBBLE    (BUB),
        .CNT_WIDTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_data  (out_data),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue side of the scoreboard: an entry taken by the stage (and not
    // squashed by a same-cycle flush) is expected at the output, unchanged.
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready && !flush)
            exp_q.push_back({in_pc, in_data});
    end

    // Monitor side.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("phantom_entry", {out_pc, out_data}, 64'hx);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk("sb_pc", {32'h0, out_pc}, {32'h0, e[63:32]});
                    chk("sb_data", {32'h0, out_data}, {32'h0, e[31:0]});
                end else begin
                    chk("stall_hold", {out_pc, out_data}, exp_q[0]);
                end
            end else begin
                chk("bubble_pc", {32'h0, out_pc}, 64'h0);
                chk("bubble_data", {32'h0, out_data}, {32'h0, BUB});
            end
            if (flush) exp_q.delete();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] d);
        in_valid = v;
        in_pc    = pc;
        in_data  = d;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drv(1'b0, 32'h0, 32'h0);

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        chk("rst_occupancy", {62'h0, occupancy}, 64'h0);
        chk("rst_out_data", {32'h0, out_data}, {32'h0, BUB});
        chk("rst_out_pc", {32'h0, out_pc}, 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);

        // Streaming at full rate
        drv(1'b1, 32'h0, 32'hA000_0000); cyc();
        chk("str0_pc", {32'h0, out_pc}, 64'h0);
        chk("str0_occ", {62'h0, occupancy}, 64'h1);
        drv(1'b1, 32'h4, 32'hA000_0004); cyc();
        chk("str1_pc", {32'h0, out_pc}, 64'h4);
        chk("str1_occ", {62'h0, occupancy}, 64'h1);
        drv(1'b1, 32'h8, 32'hA000_0008); cyc();
        chk("str2_pc", {32'h0, out_pc}, 64'h8);
        chk("str2_occ", {62'h0, occupancy}, 64'h1);
        drv(1'b0, 32'h0, 32'h0); cyc();
        chk("str_drain_occ", {62'h0, occupancy}, 64'h0);
        chk("str_drain_valid", {63'h0, out_valid}, 64'h0);

        // Backpressure
        out_ready = 1'b0;
        drv(1'b1, 32'h10, 32'hB000_0010); cyc();
        chk("bp0_occ", {62'h0, occupancy}, 64'h1);
        chk("bp0_in_ready", {63'h0, in_ready}, 64'h1);
        drv(1'b1, 32'h14, 32'hB000_0014); cyc();
        chk("bp1_occ", {62'h0, occupancy}, 64'h2);
        chk("bp1_in_ready", {63'h0, in_ready}, 64'h0);
        chk("bp1_pc", {32'h0, out_pc}, 64'h10);
        drv(1'b1, 32'h18, 32'hB000_0018); cyc();
        cyc(); cyc(); cyc();
        chk("bp_hold_occ", {62'h0, occupancy}, 64'h2);
        chk("bp_hold_pc", {32'h0, out_pc}, 64'h10);
        chk("bp_hold_data", {32'h0, out_data}, 64'hB000_0010);
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt_sat", {62'h0, stall_cnt}, 64'h3);
        chk("flush_cnt_zero", {62'h0, flush_cnt}, 64'h0);
`endif
        out_ready = 1'b1; cyc();
        chk("bp_rel0_pc", {32'h0, out_pc}, 64'h14);
        chk("bp_rel0_occ", {62'h0, occupancy}, 64'h1);
        chk("bp_rel0_in_ready", {63'h0, in_ready}, 64'h1);
        cyc();
        chk("bp_rel1_pc", {32'h0, out_pc}, 64'h18);
        drv(1'b0, 32'h0, 32'h0); cyc();
        chk("bp_drain_occ", {62'h0, occupancy}, 64'h0);

        // Flush in ONE with same-cycle out_fire (delivered) and in_fire (dropped)
        out_ready = 1'b0;
        drv(1'b1, 32'h30, 32'hC000_0030); cyc();
        chk("fl1_occ", {62'h0, occupancy}, 64'h1);
        out_ready = 1'b1;
        drv(1'b1, 32'h34, 32'hC000_0034); flush = 1'b1; cyc();
        flush = 1'b0; drv(1'b0, 32'h0, 32'h0);
        chk("fl1_after_occ", {62'h0, occupancy}, 64'h0);
        chk("fl1_after_valid", {63'h0, out_valid}, 64'h0);
`ifdef PIPE_STAGE_STATS_EN
        chk("flush_cnt_one", {62'h0, flush_cnt}, 64'h1);
`endif
        cyc();
        chk("fl1_dropped", {63'h0, out_valid}, 64'h0);

        // Flush in FULL with an entry offered upstream
        out_ready = 1'b0;
        drv(1'b1, 32'h20, 32'hD000_0020); cyc();
        drv(1'b1, 32'h24, 32'hD000_0024); cyc();
        chk("fl2_occ", {62'h0, occupancy}, 64'h2);
        drv(1'b1, 32'h28, 32'hD000_0028); flush = 1'b1; cyc();
        flush = 1'b0;
        chk("fl2_after_occ", {62'h0, occupancy}, 64'h0);
        chk("fl2_after_valid", {63'h0, out_valid}, 64'h0);
        chk("fl2_after_data", {32'h0, out_data}, {32'h0, BUB});
        chk("fl2_after_pc", {32'h0, out_pc}, 64'h0);
`ifdef PIPE_STAGE_STATS_EN
        chk("flush_cnt_two", {62'h0, flush_cnt}, 64'h2);
`endif
        drv(1'b0, 32'h0, 32'h0); out_ready = 1'b1;
        cyc(); cyc();
        chk("fl2_absent", {63'h0, out_valid}, 64'h0);

        // Flush while empty is not counted
        flush = 1'b1; cyc();
        flush = 1'b0;
        chk("fl_empty_occ", {62'h0, occupancy}, 64'h0);
`ifdef PIPE_STAGE_STATS_EN
        chk("flush_cnt_empty", {62'h0, flush_cnt}, 64'h2);
`endif

        // Reset mid-cycle while FULL
        out_ready = 1'b0;
        drv(1'b1, 32'h40, 32'hE000_0040); cyc();
        drv(1'b1, 32'h44, 32'hE000_0044); cyc();
        chk("mr_occ", {62'h0, occupancy}, 64'h2);
        drv(1'b0, 32'h0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("mr_out_valid", {63'h0, out_valid}, 64'h0);
        chk("mr_in_ready", {63'h0, in_ready}, 64'h0);
        chk("mr_occ_now", {62'h0, occupancy}, 64'h0);
        chk("mr_out_data", {32'h0, out_data}, {32'h0, BUB});
        chk("mr_out_pc", {32'h0, out_pc}, 64'h0);
`ifdef PIPE_STAGE_STATS_EN
        chk("mr_stall_cnt", {62'h0, stall_cnt}, 64'h0);
        chk("mr_flush_cnt", {62'h0, flush_cnt}, 64'h0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mr_rel_in_ready", {63'h0, in_ready}, 64'h1);
        chk("mr_rel_occ", {62'h0, occupancy}, 64'h0);

        // Stage still works after reset
        out_ready = 1'b1;
        @(posedge clk); #1;
        drv(1'b1, 32'h50, 32'hF000_0050); cyc();
        chk("post_mr_pc", {32'h0, out_pc}, 64'h50);
        drv(1'b0, 32'h0, 32'h0);
        cyc(); cyc();
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload (instruction/control) width in bits.
REQ-002 SHALL have parameter PC_WIDTH, default 32, program-counter field width.
REQ-003 SHALL have parameter BUBBLE, default all-zeros (WIDTH bits), payload driven when empty.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  upstream has a stage entry.
REQ-008 SHALL have port in_ready  output  1  stage accepts an entry this cycle.
REQ-009 SHALL have port in_pc  input  PC_WIDTH  upstream PC.
REQ-010 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-011 SHALL have port flush  input  1  synchronous squash of all held entries.
REQ-012 SHALL have port out_valid  output  1  stage presents an entry.
REQ-013 SHALL have port out_ready  input  1  downstream accepts (low = stall).
REQ-014 SHALL have port out_pc  output  PC_WIDTH  presented PC.
REQ-015 SHALL have port out_data  output  WIDTH  presented payload.
REQ-016 SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-017 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-018 SHALL implement a 2-entry elastic register (main + skid) with states EMPTY, ONE, FULL.
REQ-019 SHALL transition EMPTY: in_fire -> ONE, main <= input.
REQ-020 SHALL transition ONE: in_fire & !out_fire -> FULL, skid <= input; in_fire & out_fire -> ONE, main <= input; out_fire only -> EMPTY.
REQ-021 SHALL transition FULL: out_fire -> ONE, main <= skid; otherwise hold.
REQ-022 SHALL drive in_ready = !reset & (state != FULL), from registered state only (no out_ready combinational path).
REQ-023 SHALL drive out_valid = (state != EMPTY); out_pc/out_data from main.
REQ-024 SHALL give latency of one cycle: entry accepted at edge N is presented after edge N.
REQ-025 SHALL sustain one transfer per cycle while out_ready stays high.
REQ-026 SHALL hold out_pc/out_data stable while out_valid & !out_ready.
REQ-027 SHALL preserve entry order; no entry dropped or duplicated except by flush.
REQ-028 SHALL, on flush, go to EMPTY at the next edge, overriding all transitions; a same-cycle in_fire is discarded; a same-cycle out_fire counts as delivered.
REQ-029 SHALL drive out_data = BUBBLE and out_pc = 0 when out_valid is low.
REQ-030 SHALL drive occupancy = 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-031 SHALL, on reset assertion, immediately force state EMPTY, out_valid 0, in_ready 0, occupancy 0, out_data BUBBLE, out_pc 0.
REQ-032 SHALL present in_ready = 1 from the first cycle after reset deassertion.
REQ-033 SHALL discard held entries when reset asserts mid-operation; no partial transfer completes.

Configuration
REQ-034 SHALL, with PIPE_STAGE_STATS_EN defined, add outputs stall_cnt and flush_cnt (CNT_WIDTH each).
REQ-035 SHALL count stall_cnt on cycles with out_valid & !out_ready; flush_cnt on flush cycles with occupancy != 0; both saturate at all-ones; both reset to 0.
REQ-036 SHALL, without PIPE_STAGE_STATS_EN, omit both ports and all counter logic; all other behaviour identical.

Structure
REQ-037 SHALL take the state encoding (EMPTY=0, ONE=1, FULL=2) and default BUBBLE constant from shared package pipe_pkg.
REQ-038 SHALL implement counters as one sub-module pipe_sat_counter (enable, saturating, async reset), instantiated twice only under PIPE_STAGE_STATS_EN.

Verification
REQ-039 SHALL cover streaming: out_ready=1, PCs 0x0,0x4,0x8 on consecutive cycles -> out_pc 0x0,0x4,0x8 one cycle later each, occupancy stays 1.
REQ-040 SHALL cover backpressure: out_ready=0, send 0x10,0x14,0x18 -> 0x10,0x14 accepted, occupancy 2, in_ready 0, 0x18 held upstream; out_ready=1 -> 0x10,0x14,0x18 in order.
REQ-041 SHALL cover flush in FULL with in_valid=1 -> next cycle occupancy 0, out_valid 0, out_data BUBBLE, incoming entry absent at output.
REQ-042 SHALL cover reset asserted mid-cycle with occupancy 2 -> out_valid and in_ready low immediately; after release in_ready 1, occupancy 0.
REQ-043 SHALL cover (PIPE_STAGE_STATS_EN, CNT_WIDTH=2) 5 stall cycles -> stall_cnt 3 (saturated); one flush with occupancy 1 -> flush_cnt 1.
